// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with two write ports, write->read forwarding, optional zero R0 and busy scoreboard
//   clk, rst             clock (rising edge), synchronous active-high reset
//   raddr/rdata/rbusy    NRD packed read ports: address in, data and pending-write flag out
//   wen0/waddr0/wdata0   write port 0 (ALU writeback)
//   wen1/waddr1/wdata1   write port 1 (load writeback), wins on address collision
//   rsv_en/rsv_addr      reserve a destination register (mark busy)
//   busy_vec             scoreboard, one bit per register
//   wconf                both write ports target the same valid register this cycle
module regfile_mp #(
    parameter int DSIZE   = 16,
    parameter int NREG    = 8,
    parameter int ASIZE   = 3,
    parameter int NRD     = 2,
    parameter int R0_ZERO = 1,
    parameter int INIT_R1 = 5,
    parameter int INIT_R2 = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NRD*ASIZE-1:0]   raddr,
    output logic [NRD*DSIZE-1:0]   rdata,
    output logic [NRD-1:0]         rbusy,
    input  logic                   wen0,
    input  logic [ASIZE-1:0]       waddr0,
    input  logic [DSIZE-1:0]       wdata0,
    input  logic                   wen1,
    input  logic [ASIZE-1:0]       waddr1,
    input  logic [DSIZE-1:0]       wdata1,
    input  logic                   rsv_en,
    input  logic [ASIZE-1:0]       rsv_addr,
    output logic [NREG-1:0]        busy_vec,
    output logic                   wconf
);
    localparam logic [ASIZE:0] L_NREG = (ASIZE+1)'(NREG);
    logic [DSIZE-1:0] r_regs [NREG];
    logic [NREG-1:0]  r_busy;
    logic             w_v0, w_v1;
    logic [NREG-1:0]  w_we0, w_we1, w_set;
    // a write only counts if it lands in a real, writable register
    assign w_v0  = wen0 && ({1'b0, waddr0} < L_NREG) && !(R0_ZERO != 0 && waddr0 == '0);
    assign w_v1  = wen1 && ({1'b0, waddr1} < L_NREG) && !(R0_ZERO != 0 && waddr1 == '0);
    assign wconf = w_v0 && w_v1 && waddr0 == waddr1;
    assign busy_vec = r_busy;
    always_comb begin
        w_we0 = '0;
        w_we1 = '0;
        w_set = '0;
        for (int i = 0; i < NREG; i++) begin
            w_we1[i] = w_v1 && waddr1 == ASIZE'(i);
            w_we0[i] = w_v0 && !wconf && waddr0 == ASIZE'(i);
            w_set[i] = rsv_en && rsv_addr == ASIZE'(i) && !(R0_ZERO != 0 && i == 0);
        end
    end
    // a reservation in the same cycle as a write marks a newer producer, so set beats clear
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREG; i++) begin
            if (rst) begin
                r_regs[i] <= i == 1 ? DSIZE'(INIT_R1) : i == 2 ? DSIZE'(INIT_R2) : '0;
                r_busy[i] <= 1'b0;
            end else begin
                if (w_we1[i])
                    r_regs[i] <= wdata1;
                else if (w_we0[i])
                    r_regs[i] <= wdata0;
                if (w_set[i])
                    r_busy[i] <= 1'b1;
                else if (w_we0[i] || w_we1[i])
                    r_busy[i] <= 1'b0;
            end
        end
    end
    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [ASIZE-1:0] w_ra;
        logic             w_ok, w_f1, w_f0;
        assign w_ra = raddr[k*ASIZE +: ASIZE];
        assign w_ok = ({1'b0, w_ra} < L_NREG) && !(R0_ZERO != 0 && w_ra == '0);
        assign w_f1 = wen1 && waddr1 == w_ra;
        assign w_f0 = wen0 && waddr0 == w_ra;
        assign rdata[k*DSIZE +: DSIZE] = !w_ok ? '0 : w_f1 ? wdata1 : w_f0 ? wdata0 : r_regs[w_ra];
        // data arriving this cycle is already visible, so the reader need not stall
        assign rbusy[k] = w_ok && r_busy[w_ra] && !(w_f1 || w_f0);
    end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: vector table, reset sequence and randomized model check for regfile_mp
module tb_regfile_mp;
    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  raddr;
    logic [31:0] rdata;
    logic [1:0]  rbusy;
    logic        wen0, wen1, rsv_en;
    logic [2:0]  waddr0, waddr1, rsv_addr;
    logic [15:0] wdata0, wdata1;
    logic [7:0]  busy_vec;
    logic        wconf;
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;
    regfile_mp dut (
        .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
        .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
        .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_vec(busy_vec), .wconf(wconf)
    );
    typedef struct {
        logic [2:0]  ra0, ra1;
        logic        w0;
        logic [2:0]  a0;
        logic [15:0] d0;
        logic        w1;
        logic [2:0]  a1;
        logic [15:0] d1;
        logic        rv;
        logic [2:0]  ra;
        logic [15:0] e0, e1;
        logic [1:0]  eb;
        logic        ec;
        logic [7:0]  ev;
    } vec_t;
    vec_t tbl [16];
    logic [15:0] m_reg [8];
    logic [7:0]  m_busy;
    function automatic vec_t mk(int ra0, int ra1, int w0, int a0, int d0, int w1, int a1, int d1,
                                int rv, int ra, int e0, int e1, int eb, int ec, int ev);
        vec_t v;
        v.ra0 = 3'(ra0); v.ra1 = 3'(ra1);
        v.w0 = 1'(w0); v.a0 = 3'(a0); v.d0 = 16'(d0);
        v.w1 = 1'(w1); v.a1 = 3'(a1); v.d1 = 16'(d1);
        v.rv = 1'(rv); v.ra = 3'(ra);
        v.e0 = 16'(e0); v.e1 = 16'(e1); v.eb = 2'(eb); v.ec = 1'(ec); v.ev = 8'(ev);
        return v;
    endfunction
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    function automatic logic fwd(input logic [2:0] a);
        return (wen1 && waddr1 == a) || (wen0 && waddr0 == a);
    endfunction
    function automatic logic [15:0] m_read(input logic [2:0] a);
        if (a == 3'd0) return 16'h0;
        if (wen1 && waddr1 == a) return wdata1;
        if (wen0 && waddr0 == a) return wdata0;
        return m_reg[a];
    endfunction
    task automatic m_edge();
        if (rst) begin
            for (int i = 0; i < 8; i++) m_reg[i] = 16'h0;
            m_reg[1] = 16'd5;
            m_reg[2] = 16'd2;
            m_busy = 8'h0;
        end else begin
            if (wen0 && waddr0 != 3'd0) begin m_reg[waddr0] = wdata0; m_busy[waddr0] = 1'b0; end
            if (wen1 && waddr1 != 3'd0) begin m_reg[waddr1] = wdata1; m_busy[waddr1] = 1'b0; end
            if (rsv_en && rsv_addr != 3'd0) m_busy[rsv_addr] = 1'b1;
        end
    endtask
    task automatic idle();
        wen0 = 1'b0; wen1 = 1'b0; rsv_en = 1'b0;
        waddr0 = 3'd0; waddr1 = 3'd0; rsv_addr = 3'd0;
        wdata0 = 16'h0; wdata1 = 16'h0; raddr = 6'h0;
    endtask
    initial begin
        tbl[0]  = mk(0, 1, 0, 0, 0,       0, 0, 0,       0, 0, 0,      5,      0, 0, 'h00);
        tbl[1]  = mk(2, 3, 0, 0, 0,       0, 0, 0,       0, 0, 2,      0,      0, 0, 'h00);
        tbl[2]  = mk(4, 5, 0, 0, 0,       0, 0, 0,       0, 0, 0,      0,      0, 0, 'h00);
        tbl[3]  = mk(6, 7, 0, 0, 0,       0, 0, 0,       0, 0, 0,      0,      0, 0, 'h00);
        tbl[4]  = mk(3, 1, 1, 3, 'h1234,  0, 0, 0,       0, 0, 'h1234, 5,      0, 0, 'h00);
        tbl[5]  = mk(3, 3, 0, 0, 0,       0, 0, 0,       0, 0, 'h1234, 'h1234, 0, 0, 'h00);
        tbl[6]  = mk(4, 3, 1, 4, 'hAAAA,  1, 4, 'h5555,  0, 0, 'h5555, 'h1234, 0, 1, 'h00);
        tbl[7]  = mk(4, 0, 0, 0, 0,       0, 0, 0,       0, 0, 'h5555, 0,      0, 0, 'h00);
        tbl[8]  = mk(0, 0, 1, 0, 'hFFFF,  1, 0, 'hFFFF,  1, 0, 0,      0,      0, 0, 'h00);
        tbl[9]  = mk(0, 1, 0, 0, 0,       0, 0, 0,       0, 0, 0,      5,      0, 0, 'h00);
        tbl[10] = mk(5, 1, 0, 0, 0,       0, 0, 0,       1, 5, 0,      5,      0, 0, 'h00);
        tbl[11] = mk(5, 5, 0, 0, 0,       0, 0, 0,       0, 0, 0,      0,      3, 0, 'h20);
        tbl[12] = mk(5, 6, 0, 0, 0,       1, 5, 'h00C3,  0, 0, 'h00C3, 0,      0, 0, 'h20);
        tbl[13] = mk(5, 2, 0, 0, 0,       0, 0, 0,       0, 0, 'h00C3, 2,      0, 0, 'h00);
        tbl[14] = mk(6, 6, 1, 6, 'h0077,  0, 0, 0,       1, 6, 'h0077, 'h0077, 0, 0, 'h00);
        tbl[15] = mk(6, 6, 0, 0, 0,       0, 0, 0,       0, 0, 'h0077, 'h0077, 3, 0, 'h40);
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int n = 0; n < 16; n++) begin
            raddr = {tbl[n].ra1, tbl[n].ra0};
            wen0 = tbl[n].w0; waddr0 = tbl[n].a0; wdata0 = tbl[n].d0;
            wen1 = tbl[n].w1; waddr1 = tbl[n].a1; wdata1 = tbl[n].d1;
            rsv_en = tbl[n].rv; rsv_addr = tbl[n].ra;
            #1;
            check($sformatf("vec%0d rdata0", n), 32'(rdata[15:0]), 32'(tbl[n].e0));
            check($sformatf("vec%0d rdata1", n), 32'(rdata[31:16]), 32'(tbl[n].e1));
            check($sformatf("vec%0d rbusy", n), 32'(rbusy), 32'(tbl[n].eb));
            check($sformatf("vec%0d wconf", n), 32'(wconf), 32'(tbl[n].ec));
            check($sformatf("vec%0d busy_vec", n), 32'(busy_vec), 32'(tbl[n].ev));
            tick();
        end
        // reset while R6 is pending, with a write and a reservation that must be overridden
        rst = 1'b1;
        wen1 = 1'b1; waddr1 = 3'd6; wdata1 = 16'h1111;
        rsv_en = 1'b1; rsv_addr = 3'd7;
        tick();
        rst = 1'b0;
        idle();
        raddr = {3'd1, 3'd6};
        #1;
        check("rst_pending busy_vec", 32'(busy_vec), 32'h0);
        check("rst_pending R6", 32'(rdata[15:0]), 32'h0);
        check("rst_pending R1", 32'(rdata[31:16]), 32'd5);
        check("rst_pending rbusy", 32'(rbusy), 32'h0);
        rst = 1'b1;
        tick();
        m_edge();
        rst = 1'b0;
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 59) == 0);
            raddr = 6'($urandom);
            wen0 = 1'($urandom); waddr0 = 3'($urandom); wdata0 = 16'($urandom);
            wen1 = 1'($urandom); waddr1 = 3'($urandom); wdata1 = 16'($urandom);
            rsv_en = 1'($urandom); rsv_addr = 3'($urandom);
            if ($urandom_range(0, 3) == 0) waddr1 = waddr0;
            if ($urandom_range(0, 3) == 0) raddr[2:0] = rsv_addr;
            #1;
            for (int k = 0; k < 2; k++) begin
                logic [2:0] a;
                a = raddr[k*3 +: 3];
                check("rnd rdata", 32'(rdata[k*16 +: 16]), 32'(m_read(a)));
                check("rnd rbusy", 32'(rbusy[k]), 32'(a != 3'd0 && m_busy[a] && !fwd(a)));
            end
            check("rnd wconf", 32'(wconf), 32'(wen0 && wen1 && waddr0 == waddr1 && waddr0 != 3'd0));
            check("rnd busy_vec", 32'(busy_vec), 32'(m_busy));
            tick();
            m_edge();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
